rom_download_ctrl: RTL and testbench

//  Sequences the HPS ROM download into the arcade core's ROM/PROM banks.
//  - Decodes ioctl_addr into one of four regions and forwards each byte with a region-local address.
//  - Holds the core in reset until a complete image has loaded, plus a settle delay.
//  - Flags short or oversized images.
//  - Sits between hps_io (ioctl_*) and the core's dn_* load port, and drives the core reset.

---
 rtl/rom_download_ctrl_pkg.sv | 26 ++
 rtl/rom_download_ctrl_if.sv | 37 +++
 rtl/rom_download_ctrl_region_dec.sv | 45 ++++
 rtl/rom_download_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rom_download_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_download_ctrl_pkg.sv
// Shared types and default region map for the HPS ROM download controller.
// Region map matches the arcade image layout: CPU ROM, gfx ROM, colour PROM, sound PROM.
package dl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } dl_state_t;

    typedef logic [1:0] region_idx_t;

    localparam logic [15:0] DEF_R1_BASE       = 16'h4000;
    localparam logic [15:0] DEF_R2_BASE       = 16'h6000;
    localparam logic [15:0] DEF_R3_BASE       = 16'h6100;
    localparam logic [16:0] DEF_EXPECTED_SIZE = 17'h06200;
    localparam int          DEF_HOLD_CYCLES   = 1024;

    localparam logic [16:0] BYTE_CNT_MAX      = 17'h1FFFF;

    function automatic logic [3:0] region_onehot(input region_idx_t idx);
        region_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rom_download_ctrl_if.sv
// ioctl byte stream from hps_io plus the registered dn_* load port towards the core.
// No flow control: ioctl_wr is a one-cycle strobe, dn_wr a one-cycle pulse.
interface rom_download_ctrl_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [3:0]  dn_cs;

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        input  dn_wr,
        input  dn_addr,
        input  dn_data,
        input  dn_cs
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        output dn_wr,
        output dn_addr,
        output dn_data,
        output dn_cs
    );

endinterface

// File: rtl/rom_download_ctrl_region_dec.sv
// Combinational image address -> one-hot region select, region-local address, overflow.
// Zero latency; no backpressure.
module rom_region_dec
    import dl_pkg::*;
#(
    parameter logic [15:0] R1_BASE       = DEF_R1_BASE,
    parameter logic [15:0] R2_BASE       = DEF_R2_BASE,
    parameter logic [15:0] R3_BASE       = DEF_R3_BASE,
    parameter logic [16:0] EXPECTED_SIZE = DEF_EXPECTED_SIZE
) (
    input  logic [24:0] i_addr,
    output logic [3:0]  o_cs,
    output logic [15:0] o_local_addr,
    output logic        o_overflow
);

    region_idx_t w_idx;
    logic [15:0] w_base;

    always_comb begin
        w_idx      = 2'd0;
        w_base     = 16'h0000;
        o_overflow = 1'b0;
        if (i_addr < {9'd0, R1_BASE}) begin
            w_idx  = 2'd0;
            w_base = 16'h0000;
        end else if (i_addr < {9'd0, R2_BASE}) begin
            w_idx  = 2'd1;
            w_base = R1_BASE;
        end else if (i_addr < {9'd0, R3_BASE}) begin
            w_idx  = 2'd2;
            w_base = R2_BASE;
        end else if (i_addr < {8'd0, EXPECTED_SIZE}) begin
            w_idx  = 2'd3;
            w_base = R3_BASE;
        end else begin
            o_overflow = 1'b1;
        end
    end

    // Every base lies below 64K, so the low 16 bits carry the full region offset.
    assign o_local_addr = i_addr[15:0] - w_base;
    assign o_cs         = o_overflow ? 4'b0000 : region_onehot(w_idx);

endmodule

// File: rtl/rom_download_ctrl.sv
// Routes HPS ROM download bytes into the core's ROM regions and holds the core in reset until a good image settles.
// Latency: 1 cycle ioctl_wr -> dn_wr; no backpressure, strobes outside LOAD are dropped.
module rom_download_ctrl
    import dl_pkg::*;
#(
    parameter logic [15:0] R1_BASE       = DEF_R1_BASE,
    parameter logic [15:0] R2_BASE       = DEF_R2_BASE,
    parameter logic [15:0] R3_BASE       = DEF_R3_BASE,
    parameter logic [16:0] EXPECTED_SIZE = DEF_EXPECTED_SIZE,
    parameter int          HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic               clk_sys,
    input  logic               reset,
    rom_download_ctrl_if.slave bus,
    output logic               core_reset,
    output logic               rom_ready,
    output logic               load_err,
    output logic [16:0]        byte_count
);

    localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    dl_state_t   r_state;
    dl_state_t   w_state_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [16:0] r_byte_cnt;
    logic        r_ovf;
    logic        r_load_err;
    logic        r_core_reset;

    logic        r_dn_wr;
    logic [15:0] r_dn_addr;
    logic [7:0]  r_dn_data;
    logic [3:0]  r_dn_cs;

    logic [3:0]  w_cs;
    logic [15:0] w_local_addr;
    logic        w_addr_ovf;
    logic        w_wr_acc;
    logic        w_start;
    logic        w_end;
    logic        w_load_ok;
    logic        w_hold_done;

    rom_region_dec #(
        .R1_BASE       (R1_BASE),
        .R2_BASE       (R2_BASE),
        .R3_BASE       (R3_BASE),
        .EXPECTED_SIZE (EXPECTED_SIZE)
    ) u_dec (
        .i_addr       (bus.ioctl_addr),
        .o_cs         (w_cs),
        .o_local_addr (w_local_addr),
        .o_overflow   (w_addr_ovf)
    );

    assign w_wr_acc    = (r_state == LOAD) && bus.ioctl_download && bus.ioctl_wr;
    assign w_load_ok   = (r_byte_cnt >= EXPECTED_SIZE) && !r_ovf;
    assign w_hold_done = (r_hold_cnt == HOLD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ioctl_download) begin
                    w_state_nxt = LOAD;
                    w_start     = 1'b1;
                end
            end
            LOAD: begin
                if (!bus.ioctl_download) begin
                    w_end       = 1'b1;
                    w_state_nxt = w_load_ok ? HOLD : IDLE;
                end
            end
            HOLD: begin
                // A new download beats the terminal count.
                if (bus.ioctl_download) begin
                    w_state_nxt = LOAD;
                    w_start     = 1'b1;
                end else if (w_hold_done) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.ioctl_download) begin
                    w_state_nxt = LOAD;
                    w_start     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= IDLE;
            r_core_reset <= 1'b1;
            r_hold_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_reset <= (w_state_nxt != RUN);
            if ((r_state == HOLD) && (w_state_nxt == HOLD)) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_byte_cnt <= 17'd0;
            r_ovf      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_byte_cnt <= 17'd0;
                r_ovf      <= 1'b0;
                r_load_err <= 1'b0;
            end else if (w_wr_acc) begin
                if (w_addr_ovf) begin
                    r_ovf <= 1'b1;
                end else if (r_byte_cnt != BYTE_CNT_MAX) begin
                    r_byte_cnt <= r_byte_cnt + 17'd1;
                end
            end
            if (w_end && !w_load_ok) begin
                r_load_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dn_wr   <= 1'b0;
            r_dn_addr <= 16'h0000;
            r_dn_data <= 8'h00;
            r_dn_cs   <= 4'b0000;
        end else begin
            r_dn_wr <= w_wr_acc && !w_addr_ovf;
            if (w_wr_acc && !w_addr_ovf) begin
                r_dn_addr <= w_local_addr;
                r_dn_data <= bus.ioctl_dout;
                r_dn_cs   <= w_cs;
            end
        end
    end

    assign bus.dn_wr   = r_dn_wr;
    assign bus.dn_addr = r_dn_addr;
    assign bus.dn_data = r_dn_data;
    assign bus.dn_cs   = r_dn_cs;

    // Combinational so the image is withdrawn in the very cycle a new download opens.
    assign rom_ready  = (r_state == RUN) && !bus.ioctl_download;
    assign core_reset = r_core_reset;
    assign load_err   = r_load_err;
    assign byte_count = r_byte_cnt;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed bench for rom_download_ctrl with a dn_* scoreboard; a second small-map instance exercises HOLD restart.
module tb_rom_download_ctrl;
    import dl_pkg::*;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    rom_download_ctrl_if bus();
    rom_download_ctrl_if bus_s();

    logic        core_reset, rom_ready, load_err;
    logic [16:0] byte_count;
    logic        s_core_reset, s_rom_ready, s_load_err;
    logic [16:0] s_byte_count;

    rom_download_ctrl #(
        .R1_BASE(16'h4000), .R2_BASE(16'h6000), .R3_BASE(16'h6100),
        .EXPECTED_SIZE(17'h06200), .HOLD_CYCLES(16)
    ) u_dut (
        .clk_sys(clk_sys), .reset(reset), .bus(bus),
        .core_reset(core_reset), .rom_ready(rom_ready),
        .load_err(load_err), .byte_count(byte_count)
    );

    rom_download_ctrl #(
        .R1_BASE(16'h0010), .R2_BASE(16'h0020), .R3_BASE(16'h0030),
        .EXPECTED_SIZE(17'h00040), .HOLD_CYCLES(16)
    ) u_small (
        .clk_sys(clk_sys), .reset(reset), .bus(bus_s),
        .core_reset(s_core_reset), .rom_ready(s_rom_ready),
        .load_err(s_load_err), .byte_count(s_byte_count)
    );

    typedef struct packed {
        logic [3:0]  cs;
        logic [15:0] addr;
        logic [7:0]  data;
    } dn_t;

    dn_t sb_q[$];
    int  sb_cyc[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic dn_t model(input logic [24:0] a);
        dn_t r;
        r.data = pat(a);
        if (a < 25'h4000) begin
            r.cs = 4'b0001; r.addr = a[15:0];
        end else if (a < 25'h6000) begin
            r.cs = 4'b0010; r.addr = a[15:0] - 16'h4000;
        end else if (a < 25'h6100) begin
            r.cs = 4'b0100; r.addr = a[15:0] - 16'h6000;
        end else begin
            r.cs = 4'b1000; r.addr = a[15:0] - 16'h6100;
        end
        return r;
    endfunction

    // Drive one strobe on the main bus at the current negedge; in-range bytes go to the scoreboard.
    task automatic drive_wr(input logic [24:0] a, input bit fwd);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = pat(a);
        if (fwd) begin
            sb_q.push_back(model(a));
            sb_cyc.push_back(cyc + 1);
        end
    endtask

    always @(negedge clk_sys) begin
        if (sb_cyc.size() != 0 && sb_cyc[0] <= cyc) begin
            check("dn_wr_pulse", bus.dn_wr, 1'b1);
            check("dn_word", {bus.dn_cs, bus.dn_addr, bus.dn_data}, sb_q[0]);
            void'(sb_q.pop_front());
            void'(sb_cyc.pop_front());
        end else if (bus.dn_wr !== 1'b0) begin
            check("dn_wr_spurious", bus.dn_wr, 1'b0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
        bus_s.ioctl_download = 1'b0; bus_s.ioctl_wr = 1'b0; bus_s.ioctl_addr = '0; bus_s.ioctl_dout = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_rom_ready", rom_ready, 1'b0);
        check("rst_load_err", load_err, 1'b0);
        check("rst_byte_count", byte_count, 17'd0);
        check("rst_dn", {bus.dn_wr, bus.dn_cs, bus.dn_addr, bus.dn_data}, 29'd0);
        check("rst_state", u_dut.r_state, IDLE);
        reset = 1'b0;

        // Idle with stray strobes: nothing forwarded, core held in reset.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            check("idle_core_reset", core_reset, 1'b1);
            check("idle_rom_ready", rom_ready, 1'b0);
            bus.ioctl_wr   = i[0];
            bus.ioctl_addr = 25'(i);
        end
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check("idle_byte_count", byte_count, 17'd0);

        // Full image, ending with a strobe coincident with the download fall.
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("full_enter_load", u_dut.r_state, LOAD);
        for (int a = 0; a < 'h6200; a++) begin
            if (a == 'h4004)
                check("addr_4003", {bus.dn_wr, bus.dn_cs, bus.dn_addr}, {1'b1, 4'b0010, 16'h0003});
            if (a == 'h6106)
                check("addr_6105", {bus.dn_wr, bus.dn_cs, bus.dn_addr}, {1'b1, 4'b1000, 16'h0005});
            drive_wr(25'(a), 1'b1);
            @(negedge clk_sys);
        end
        bus.ioctl_download = 1'b0;
        drive_wr(25'h0, 1'b0);
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        check("coincident_wr_dropped", bus.dn_wr, 1'b0);
        check("full_byte_count", byte_count, 17'h06200);
        check("full_enter_hold", u_dut.r_state, HOLD);
        check("full_load_err", load_err, 1'b0);
        repeat (15) @(negedge clk_sys);
        check("hold_rom_ready_early", rom_ready, 1'b0);
        check("hold_core_reset", core_reset, 1'b1);
        @(negedge clk_sys);
        check("hold_rom_ready_16", rom_ready, 1'b1);
        check("run_core_reset", core_reset, 1'b0);
        @(negedge clk_sys);

        // Restart from RUN, then a short image in that download.
        bus.ioctl_download = 1'b1;
        #1;
        check("restart_rom_ready_same_cycle", rom_ready, 1'b0);
        check("restart_core_reset_not_yet", core_reset, 1'b0);
        @(negedge clk_sys);
        check("restart_core_reset_next", core_reset, 1'b1);
        check("restart_byte_count", byte_count, 17'd0);
        for (int a = 0; a < 'h6000; a++) begin
            drive_wr(25'(a), 1'b1);
            @(negedge clk_sys);
        end
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("short_load_err", load_err, 1'b1);
        check("short_state", u_dut.r_state, IDLE);
        check("short_byte_count", byte_count, 17'h06000);
        repeat (4) @(negedge clk_sys);
        check("short_load_err_sticky", load_err, 1'b1);
        check("short_core_reset", core_reset, 1'b1);
        check("short_rom_ready", rom_ready, 1'b0);

        // Reset pulse in the middle of a download.
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("start_clears_load_err", load_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_wr(25'(16'h0100 + i), 1'b1);
            @(negedge clk_sys);
        end
        check("midload_byte_count", byte_count, 17'd5);
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check("midreset_state", u_dut.r_state, IDLE);
        check("midreset_byte_count", byte_count, 17'd0);
        check("midreset_core_reset", core_reset, 1'b1);
        @(negedge clk_sys);

        // Full image with an out-of-range byte inserted.
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int a = 0; a < 'h6200; a++) begin
            drive_wr(25'(a), 1'b1);
            @(negedge clk_sys);
            if (a == 'h3000) begin
                drive_wr(25'h6200, 1'b0);
                @(negedge clk_sys);
                check("ovf_no_dn_wr", bus.dn_wr, 1'b0);
                check("ovf_dn_held", {bus.dn_cs, bus.dn_addr, bus.dn_data},
                      {4'b0001, 16'h3000, pat(25'h3000)});
            end
        end
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("ovf_load_err", load_err, 1'b1);
        check("ovf_byte_count", byte_count, 17'h06200);
        check("ovf_state", u_dut.r_state, IDLE);
        check("ovf_rom_ready", rom_ready, 1'b0);

        // Small map: download rises on the HOLD terminal cycle.
        bus_s.ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int a = 0; a < 'h40; a++) begin
            bus_s.ioctl_wr = 1'b1;
            bus_s.ioctl_addr = 25'(a);
            bus_s.ioctl_dout = pat(25'(a));
            @(negedge clk_sys);
        end
        check("small_byte_count", s_byte_count, 17'h00040);
        bus_s.ioctl_wr = 1'b0;
        bus_s.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("small_enter_hold", u_small.r_state, HOLD);
        repeat (15) @(negedge clk_sys);
        check("small_terminal_count", u_small.r_hold_cnt, 4'd15);
        check("small_rom_ready_pre", s_rom_ready, 1'b0);
        bus_s.ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("small_load_wins", u_small.r_state, LOAD);
        check("small_rom_ready_post", s_rom_ready, 1'b0);
        check("small_core_reset", s_core_reset, 1'b1);
        check("small_restart_count", s_byte_count, 17'd0);
        repeat (4) @(negedge clk_sys);
        check("small_rom_ready_stays", s_rom_ready, 1'b0);
        bus_s.ioctl_download = 1'b0;

        repeat (2) @(negedge clk_sys);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
